// File: rtl/score_counter_if.sv
// Bundle of the score keeper's control inputs, player events, display select
// and outputs. The game/video side uses the master modport; score_counter
// uses the slave modport.
//   GAME_ON        scoring enable while the playtime timer runs
//   RESET_SCORE_N  active-low clear of both scores
//   SCORE1/SCORE2  rocket-at-top level inputs per player
//   DIGIT_SEL      digit requested by video (0=P1 tens .. 3=P2 units)
//   SEG_N          active-low segments {g,f,e,d,c,b,a} of the selected digit
//   SCORE1_BCD/SCORE2_BCD  scores, {tens,units} in BCD
//   SCORE_SND      one-cycle pulse per accepted point
interface score_counter_if;
  logic       GAME_ON;
  logic       RESET_SCORE_N;
  logic       SCORE1;
  logic       SCORE2;
  logic [1:0] DIGIT_SEL;
  logic [6:0] SEG_N;
  logic [7:0] SCORE1_BCD;
  logic [7:0] SCORE2_BCD;
  logic       SCORE_SND;

  modport master (
    output GAME_ON, RESET_SCORE_N, SCORE1, SCORE2, DIGIT_SEL,
    input  SEG_N, SCORE1_BCD, SCORE2_BCD, SCORE_SND
  );

  modport slave (
    input  GAME_ON, RESET_SCORE_N, SCORE1, SCORE2, DIGIT_SEL,
    output SEG_N, SCORE1_BCD, SCORE2_BCD, SCORE_SND
  );
endinterface

// File: rtl/score_counter.sv
// Two-player BCD score keeper with per-player holdoff, a sound pulse per
// accepted point and a registered 7-segment decoder for the video stage.
//   CLK_DRV  system clock (single domain)
//   RST_N    synchronous active-low reset
//   bus      score_counter_if.slave (controls, events, display select, outputs)
// Parameters:
//   MAX_SCORE  highest score value, 1..99
//   WRAP       0: saturate at MAX_SCORE, 1: wrap to 0 after MAX_SCORE
//   HOLDOFF    cycles after an accepted point during which that player's
//              rises are ignored; 0 disables the holdoff
module score_counter #(
  parameter int unsigned MAX_SCORE = 99,
  parameter bit          WRAP      = 1'b0,
  parameter int unsigned HOLDOFF   = 5727200
) (
  input logic            CLK_DRV,
  input logic            RST_N,
  score_counter_if.slave bus
);

  localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;
  localparam logic [7:0] MAX_BCD = {4'(MAX_SCORE / 10), 4'(MAX_SCORE % 10)};
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // BCD increment with saturate/wrap at MAX_SCORE; nibbles stay within 0..9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == MAX_BCD) return WRAP ? 8'h00 : v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Active-low {g,f,e,d,c,b,a}; non-BCD nibbles blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  logic          in1_q, in1_d, in2_q, in2_d;
  logic [7:0]    score1_q, score1_d, score2_q, score2_d;
  logic [HW-1:0] holdoff1_q, holdoff1_d, holdoff2_q, holdoff2_d;
  logic          snd_q, snd_d;
  logic [6:0]    seg_q, seg_d;
  logic          accept1, accept2;
  logic [3:0]    digit;
  logic          is_tens;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    in1_d      = bus.SCORE1;
    in2_d      = bus.SCORE2;
    score1_d   = score1_q;
    score2_d   = score2_q;
    holdoff1_d = (holdoff1_q != '0) ? holdoff1_q - HW'(1) : '0;
    holdoff2_d = (holdoff2_q != '0) ? holdoff2_q - HW'(1) : '0;

    // A rise that is not accepted is simply lost.
    accept1 = bus.SCORE1 & ~in1_q & bus.GAME_ON & bus.RESET_SCORE_N & (holdoff1_q == '0);
    accept2 = bus.SCORE2 & ~in2_q & bus.GAME_ON & bus.RESET_SCORE_N & (holdoff2_q == '0);
    snd_d   = accept1 | accept2;

    // Clear wins over any same-cycle increment (accept is already gated by it).
    if (!bus.RESET_SCORE_N) begin
      score1_d   = 8'h00;
      score2_d   = 8'h00;
      holdoff1_d = '0;
      holdoff2_d = '0;
    end else begin
      if (accept1) begin
        score1_d   = bcd_inc(score1_q);
        holdoff1_d = HOLD_LOAD;
      end
      if (accept2) begin
        score2_d   = bcd_inc(score2_q);
        holdoff2_d = HOLD_LOAD;
      end
    end

    is_tens = ~bus.DIGIT_SEL[0];
    case (bus.DIGIT_SEL)
      2'd0:    digit = score1_q[7:4];
      2'd1:    digit = score1_q[3:0];
      2'd2:    digit = score2_q[7:4];
      default: digit = score2_q[3:0];
    endcase
    // Leading-zero suppression applies to tens digits only.
    seg_d = (is_tens && digit == 4'd0) ? SEG_BLANK : seg_decode(digit);
  end

  always_ff @(posedge CLK_DRV) begin
    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    if (!RST_N) begin
      // Edge detectors load 1 so an input held high across reset release does not score.
      in1_q      <= 1'b1;
      in2_q      <= 1'b1;
      score1_q   <= 8'h00;
      score2_q   <= 8'h00;
      holdoff1_q <= '0;
      holdoff2_q <= '0;
      snd_q      <= 1'b0;
      seg_q      <= SEG_BLANK;
    end else begin
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      holdoff1_q <= holdoff1_d;
      holdoff2_q <= holdoff2_d;
      snd_q      <= snd_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.SCORE1_BCD = score1_q;
  assign bus.SCORE2_BCD = score2_q;
  assign bus.SCORE_SND  = snd_q;
  assign bus.SEG_N      = seg_q;

endmodule
